seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Reads a multiplexed 4-digit common-anode 7-segment bus (the cathode/AN pair the kitchen
//  timer drives) and reconstructs the displayed digits as BCD. It is the receiving end of the
//  display interface. It is used on-board for self-check and in benches as a synthesizable monitor.
//  Filters scan-transition ghosting, flags illegal patterns and detects a dead display.
// PARAMETERS
//  SETTLE_CYCLES   4        consecutive identical samples required before a digit is captured (>=1)
//  TIMEOUT_CYCLES  1048576  cycles with no single-anode-active sample before display_off asserts
//  CNT_W           21       width of the timeout counter (>= clog2(TIMEOUT_CYCLES+1))
// PORTS
//  clk           in   1   system clock; every register is in this single domain
//  rst           in   1   synchronous, active-high reset
//  cathode       in   7   segments, active-low, bit0=a ... bit6=g
//  AN            in   4   digit enables, active-low, AN[0]=rightmost digit
//  digits        out  16  live BCD per digit, digits[4i+3:4i] = digit i; 4'hF = blank
//  frame_digits  out  16  snapshot of digits, taken when a frame completes
//  frame_strobe  out  1   1-cycle pulse: frame_digits updated
//  blank         out  4   per-digit flag: the last capture was all segments off
//  err_pattern   out  1   1-cycle pulse: the captured pattern is not a legal glyph
//  err_multi     out  1   1-cycle pulse: more than one AN low was held stable
//  display_off   out  1   level: no valid single-anode activity for TIMEOUT_CYCLES cycles
// BEHAVIOUR
//  - Reset: digits=16'hFFFF, frame_digits=16'hFFFF, blank=4'hF, all pulses 0, display_off=0.
//    The seen mask, the stability counter and the timeout counter are cleared. Reset mid-scan
//    discards any partial frame.
//  - Input stage: {AN,cathode} is registered every cycle (s_pair). stab_cnt increments while
//    s_pair equals its previous value and saturates at SETTLE_CYCLES. On any change it reloads to 1.
//  - FSM on the sampled pair:
//    - WAIT: the pair is unstable. Move to CAPTURE on the edge where stab_cnt reaches SETTLE_CYCLES.
//    - CAPTURE: a single cycle. Act on the AN code:
//      - exactly one AN low: decode the cathode into digit i; set seen[i].
//      - AN=4'hF: nothing captured.
//      - more than one AN low: pulse err_multi; nothing captured.
//      Then go to HOLD.
//    - HOLD: stay until the pair changes, then go to WAIT. No recapture of an unchanged pair.
//  - Capture latency: digit i updates SETTLE_CYCLES+1 edges after the input pair last changed.
//  - Decode:
//    - the 10 standard glyphs give 0-9. The 6 segment is a,f,g,e,c,d; the 9 segment is a,b,c,d,f,g.
//    - 7'h7F gives 4'hF with blank[i]=1.
//    - any other pattern gives 4'hE with blank[i]=0, and err_pattern pulses in the CAPTURE cycle.
//  - Frame: in the cycle after seen==4'hF, frame_digits<=digits and frame_strobe=1 for one cycle.
//    seen clears in that same cycle. If a capture also happens in that cycle, its seen bit survives.
//  - Timeout: the counter resets whenever a single-anode capture occurs. Otherwise it increments,
//    saturating. display_off=1 once it reaches TIMEOUT_CYCLES; it clears on the next valid capture.
//  - Wrap/rescan: the same digit captured again before the frame completes overwrites digits[i].
//    It does not strobe twice.
// CONFIGURATION
//  - SEG_HEX_EN defined: the glyphs A,b,C,d,E,F also decode to 4'hA-4'hF. Blank then uses a
//    separate blank flag only, and a blank digit reads 4'h0. Illegal patterns read 4'h0 and pulse err_pattern.
//  - SEG_HEX_EN undefined: those six glyphs are illegal (4'hE plus err_pattern) and blank reads 4'hF.
// STRUCTURE
//  - Package seg_pkg holds:
//    - localparam segment constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK=7'h7F (active-low)
//    - CODE_BLANK=4'hF and CODE_ERR=4'hE
//    - the FSM state enum {WAIT, CAPTURE, HOLD}
//  - One combinational sub-module, seg7_to_bcd (cathode to {code, is_blank, is_err}), shared with
//    the bench. The top level holds the sampler, stability counter, FSM, seen mask and timeout counter.
// TESTING
//  T1 reset then scan AN=1110/cath=7'h40, 1101/7'h12, 1011/7'h79, 0111/7'h00, 8 cycles each
//     -> frame_strobe once, frame_digits=16'h8150, blank=0.
//  T2 hold AN=1110, cath=7'h40 for exactly SETTLE_CYCLES-1 cycles, then change
//     -> digits unchanged (16'hFFFF), no capture.
//  T3 AN=1011 with cath=7'h36 held 8 cycles -> err_pattern 1-cycle pulse; digits[11:8]=4'hE
//     (SEG_HEX_EN off).
//  T4 AN=1100, cath=7'h40 held 8 cycles -> err_multi pulse; digits and seen unchanged.
//  T5 AN=4'hF for TIMEOUT_CYCLES cycles (TIMEOUT_CYCLES=64 in the bench) -> display_off=1 at
//     cycle 64; the next valid capture clears it.
//  T6 assert rst after 3 of 4 digits are captured, then scan 1 digit -> no frame_strobe;
//     all outputs at reset values for the first cycle after rst.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low glyph
// patterns (bit0=a ... bit6=g), special BCD codes and the scan FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational glyph decoder: active-low cathode pattern to BCD code plus
// blank / illegal flags. Build option SEG_HEX_EN adds the A-F glyphs; in that
// build blank and illegal patterns read 4'h0 and only the flags tell them apart.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] cathode,
  output logic [3:0] code,
  output logic       is_blank,
  output logic       is_err
);

  // Pattern lookup; anything not listed is an illegal glyph.
  always_comb begin
    code     = 4'h0;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (cathode)
      SEG_0: code = 4'd0;
      SEG_1: code = 4'd1;
      SEG_2: code = 4'd2;
      SEG_3: code = 4'd3;
      SEG_4: code = 4'd4;
      SEG_5: code = 4'd5;
      SEG_6: code = 4'd6;
      SEG_7: code = 4'd7;
      SEG_8: code = 4'd8;
      SEG_9: code = 4'd9;
`ifdef SEG_HEX_EN
      SEG_A: code = 4'hA;
      SEG_B: code = 4'hB;
      SEG_C: code = 4'hC;
      SEG_D: code = 4'hD;
      SEG_E: code = 4'hE;
      SEG_F: code = 4'hF;
      SEG_BLANK: begin
        code     = 4'h0;
        is_blank = 1'b1;
      end
      default: begin
        code   = 4'h0;
        is_err = 1'b1;
      end
`else
      SEG_BLANK: begin
        code     = CODE_BLANK;
        is_blank = 1'b1;
      end
      default: begin
        code   = CODE_ERR;
        is_err = 1'b1;
      end
`endif
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed 4-digit common-anode 7-segment bus. Samples
// {AN,cathode}, waits for the pair to settle, decodes the lit digit into BCD,
// assembles frames, and flags illegal glyphs, multi-anode drive and a dead
// display. Build option SEG_HEX_EN (see seg7_to_bcd) enables hex glyphs.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  cathode,
  input  logic [3:0]  AN,
  output logic [15:0] digits,
  output logic [15:0] frame_digits,
  output logic        frame_strobe,
  output logic [3:0]  blank,
  output logic        err_pattern,
  output logic        err_multi,
  output logic        display_off
);

  localparam int               SW         = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]    SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_MAX    = CNT_W'(TIMEOUT_CYCLES);

  // Stability counter step: reload on change, otherwise count up and saturate.
  function automatic logic [SW-1:0] stab_step(input logic [SW-1:0] cur, input logic chg);
    if (chg)
      return SW'(1);
    else if (cur >= SETTLE_MAX)
      return SETTLE_MAX;
    else
      return cur + 1'b1;
  endfunction

  // Saturating increment for the dead-display counter.
  function automatic logic [CNT_W-1:0] tmo_step(input logic [CNT_W-1:0] cur);
    if (cur >= TMO_MAX)
      return TMO_MAX;
    else
      return cur + 1'b1;
  endfunction

  logic [10:0]      in_pair;
  logic [10:0]      s_pair;
  logic             changed;
  logic [SW-1:0]    stab_cnt;
  logic [SW-1:0]    stab_next;
  logic             settled;
  scan_state_e      state;
  scan_state_e      state_next;
  logic [3:0]       s_an;
  logic [6:0]       s_cath;
  logic             an_single;
  logic             an_multi;
  logic [1:0]       an_idx;
  logic [3:0]       dec_code;
  logic             dec_blank;
  logic             dec_err;
  logic             cap_en;
  logic [3:0]       cap_mask;
  logic [3:0]       seen;
  logic [CNT_W-1:0] tcnt;

  assign in_pair   = {AN, cathode};
  assign changed   = (in_pair != s_pair);
  assign stab_next = stab_step(stab_cnt, changed);
  // True on the edge where the counter first reaches the settle count.
  assign settled   = (stab_next == SETTLE_MAX);
  assign s_an      = s_pair[10:7];
  assign s_cath    = s_pair[6:0];

  // ---- stage 0: input sampling and stability tracking ----
  // Register the raw bus pair and count how long it has been unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_pair   <= {4'hF, SEG_BLANK};
      stab_cnt <= '0;
    end else begin
      s_pair   <= in_pair;
      stab_cnt <= stab_next;
    end
  end

  // Classify the sampled anode code: exactly one active-low enable, or several.
  always_comb begin
    an_single = 1'b0;
    an_multi  = 1'b0;
    an_idx    = 2'd0;
    case (s_an)
      4'b1110: begin an_single = 1'b1; an_idx = 2'd0; end
      4'b1101: begin an_single = 1'b1; an_idx = 2'd1; end
      4'b1011: begin an_single = 1'b1; an_idx = 2'd2; end
      4'b0111: begin an_single = 1'b1; an_idx = 2'd3; end
      4'b1111: ;
      default: an_multi = 1'b1;
    endcase
  end

  seg7_to_bcd u_dec (
    .cathode  (s_cath),
    .code     (dec_code),
    .is_blank (dec_blank),
    .is_err   (dec_err)
  );

  // ---- stage 1: scan FSM ----
  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= WAIT;
    else
      state <= state_next;
  end

  // Next state and single-cycle capture strobes. A pair that changes while
  // leaving CAPTURE/HOLD re-enters WAIT (or CAPTURE directly when one sample
  // is enough) so a new stable pair is never missed.
  always_comb begin
    state_next  = state;
    cap_en      = 1'b0;
    err_pattern = 1'b0;
    err_multi   = 1'b0;
    case (state)
      WAIT: begin
        if (settled)
          state_next = CAPTURE;
      end
      CAPTURE: begin
        cap_en      = an_single;
        err_pattern = an_single & dec_err;
        err_multi   = an_multi;
        if (changed)
          state_next = settled ? CAPTURE : WAIT;
        else
          state_next = HOLD;
      end
      HOLD: begin
        if (changed)
          state_next = settled ? CAPTURE : WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

  assign cap_mask = cap_en ? (4'b0001 << an_idx) : 4'b0000;

  // ---- stage 2: digit capture, frame assembly, timeout ----
  // Write the decoded digit and its blank flag into the addressed slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= 16'hFFFF;
      blank  <= 4'hF;
    end else if (cap_en) begin
      digits[{an_idx, 2'b00} +: 4] <= dec_code;
      blank[an_idx]                <= dec_blank;
    end
  end

  // Once every digit has been seen, snapshot the frame and restart the mask;
  // a capture landing in that same cycle keeps its bit for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen         <= 4'h0;
      frame_digits <= 16'hFFFF;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= (seen == 4'hF);
      if (seen == 4'hF)
        frame_digits <= digits;
      seen <= ((seen == 4'hF) ? 4'h0 : seen) | cap_mask;
    end
  end

  // Dead-display counter: cleared by any single-anode capture.
  always_ff @(posedge clk) begin
    if (rst)
      tcnt <= '0;
    else if (cap_en)
      tcnt <= '0;
    else
      tcnt <= tmo_step(tcnt);
  end

  assign display_off = (tcnt == TMO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder (default build, hex glyphs off).
// Stimulus pushes expected pulse events into a queue; a monitor pops one
// entry for every frame_strobe / err_pattern / err_multi cycle it observes.
module tb_seg_scan_decoder;

  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  localparam logic [1:0] K_FRAME = 2'd0;
  localparam logic [1:0] K_ERRP  = 2'd1;
  localparam logic [1:0] K_ERRM  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [6:0]  cathode;
  logic [3:0]  AN;
  logic [15:0] digits;
  logic [15:0] frame_digits;
  logic        frame_strobe;
  logic [3:0]  blank;
  logic        err_pattern;
  logic        err_multi;
  logic        display_off;

  int checks = 0;
  int errors = 0;
  ev_t expq[$];

  seg_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (7)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cathode      (cathode),
    .AN           (AN),
    .digits       (digits),
    .frame_digits (frame_digits),
    .frame_strobe (frame_strobe),
    .blank        (blank),
    .err_pattern  (err_pattern),
    .err_multi    (err_multi),
    .display_off  (display_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] d);
    expq.push_back(ev_t'{kind: k, data: d});
  endtask

  // Compare one observed pulse against the head of the expectation queue.
  task automatic mon_event(input logic [1:0] k, input logic [15:0] d);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL ev_unexpected: got kind %0d data %h required none", k, d);
    end else begin
      e = expq.pop_front();
      if (e.kind !== k || e.data !== d) begin
        errors++;
        $display("FAIL ev_match: got kind %0d data %h required kind %0d data %h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: sample pulses on the falling edge, away from register updates.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_strobe === 1'b1) mon_event(K_FRAME, frame_digits);
      if (err_pattern === 1'b1)  mon_event(K_ERRP, 16'h0000);
      if (err_multi === 1'b1)    mon_event(K_ERRM, 16'h0000);
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] c, input int n);
    AN      = an;
    cathode = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_digits"}, digits, 16'hFFFF);
    chk({tag, "_frame"}, frame_digits, 16'hFFFF);
    chk({tag, "_blank"}, {12'h0, blank}, 16'h000F);
    chk({tag, "_pulses"}, {13'h0, frame_strobe, err_pattern, err_multi}, 16'h0000);
    chk({tag, "_off"}, {15'h0, display_off}, 16'h0000);
  endtask

  // One reset edge with the bus idle, outputs checked, then release.
  task automatic do_reset(input string tag);
    rst     = 1'b1;
    AN      = 4'hF;
    cathode = 7'h7F;
    @(posedge clk);
    #1;
    check_reset_vals(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    AN      = 4'hF;
    cathode = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst = 1'b0;

    // T1: full scan of 0,5,1,8 gives one frame 8150
    do_reset("t1");
    expect_ev(K_FRAME, 16'h8150);
    drive(4'b1110, 7'h40, 8);
    drive(4'b1101, 7'h12, 8);
    drive(4'b1011, 7'h79, 8);
    drive(4'b0111, 7'h00, 8);
    chk("t1_digits", digits, 16'h8150);
    chk("t1_blank", {12'h0, blank}, 16'h0000);

    // T7: blank glyph and rescan of a digit within a frame, no extra strobe
    drive(4'b1101, 7'h7F, 8);
    chk("t7_blank_digits", digits, 16'h81F0);
    chk("t7_blank_flags", {12'h0, blank}, 16'h0002);
    drive(4'b1110, 7'h10, 8);
    chk("t7_rescan", digits, 16'h81F9);

    // T2: pair held one cycle short of settling is never captured
    do_reset("t2");
    drive(4'b1110, 7'h40, SETTLE - 1);
    drive(4'b1111, 7'h7F, 8);
    chk("t2_digits", digits, 16'hFFFF);
    chk("t2_blank", {12'h0, blank}, 16'h000F);

    // T3: illegal glyph and a hex glyph both flag err_pattern and read E
    do_reset("t3");
    expect_ev(K_ERRP, 16'h0000);
    drive(4'b1011, 7'h36, 8);
    chk("t3_digits", digits, 16'hFEFF);
    chk("t3_blank", {12'h0, blank}, 16'h000B);
    expect_ev(K_ERRP, 16'h0000);
    drive(4'b0111, 7'h08, 8);
    chk("t3_hex_digits", digits, 16'hEEFF);
    chk("t3_hex_blank", {12'h0, blank}, 16'h0003);

    // T4: two anodes low flags err_multi, leaves digits and seen alone
    do_reset("t4");
    expect_ev(K_ERRM, 16'h0000);
    drive(4'b1100, 7'h40, 8);
    chk("t4_digits", digits, 16'hFFFF);
    drive(4'b1011, 7'h79, 8);
    drive(4'b0111, 7'h00, 8);
    chk("t4_after", digits, 16'h81FF);

    // T5: dead display after TMO idle cycles, cleared by the next capture
    do_reset("t5");
    drive(4'hF, 7'h7F, TMO - 1);
    chk("t5_off_early", {15'h0, display_off}, 16'h0000);
    drive(4'hF, 7'h7F, 1);
    chk("t5_off_set", {15'h0, display_off}, 16'h0001);
    drive(4'hF, 7'h7F, 10);
    chk("t5_off_hold", {15'h0, display_off}, 16'h0001);
    drive(4'b1110, 7'h79, SETTLE);
    chk("t5_lat_digits", digits, 16'hFFFF);
    chk("t5_lat_off", {15'h0, display_off}, 16'h0001);
    drive(4'b1110, 7'h79, 1);
    chk("t5_cap_digits", digits, 16'hFFF1);
    chk("t5_off_clear", {15'h0, display_off}, 16'h0000);

    // T8/T9: two consecutive frames with the remaining glyphs
    do_reset("t8");
    expect_ev(K_FRAME, 16'h6432);
    drive(4'b1110, 7'h24, 8);
    drive(4'b1101, 7'h30, 8);
    drive(4'b1011, 7'h19, 8);
    drive(4'b0111, 7'h02, 8);
    expect_ev(K_FRAME, 16'h0597);
    drive(4'b1110, 7'h78, 8);
    drive(4'b1101, 7'h10, 8);
    drive(4'b1011, 7'h12, 8);
    drive(4'b0111, 7'h40, 8);
    chk("t9_digits", digits, 16'h0597);

    // T6: reset mid-frame discards the partial frame
    do_reset("t6a");
    drive(4'b1110, 7'h40, 8);
    drive(4'b1101, 7'h12, 8);
    drive(4'b1011, 7'h79, 8);
    do_reset("t6b");
    drive(4'hF, 7'h7F, 1);
    check_reset_vals("t6c");
    drive(4'b0111, 7'h00, 8);
    chk("t6_digits", digits, 16'h8FFF);

    drive(4'hF, 7'h7F, 8);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL ev_missing: got %0d pending events required 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
